// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and sizing for the CDB arbiter.
// `CDB_SIZE selects the number of CDB lanes (default 2 when not predefined).
`ifndef CDB_SIZE
`define CDB_SIZE 2
`endif

package cdb_arbiter_pkg;

  localparam int CDB_SIZE_P = `CDB_SIZE;
  localparam int ROB_SIZE   = 16;
  localparam int ROB_IDX_W  = $clog2(ROB_SIZE);
  localparam int VALUE_W    = 32;

  typedef logic [ROB_IDX_W-1:0] rob_index_t;

  typedef struct packed {
    logic                valid;
    rob_index_t          reorder;
    logic [VALUE_W-1:0]  value;
  } cdb_entry_t;

  typedef cdb_entry_t [CDB_SIZE_P-1:0] cdb_packet_t;

  // Distance of a ROB index from the head; the modulo wrap comes from the index width.
  function automatic rob_index_t rob_age(input rob_index_t idx, input rob_index_t head);
    return idx - head;
  endfunction

endpackage

// File: rtl/cdb_grant_select.sv
// Combinational multi-grant picker: pending slots -> per-lane one-hot grants.
// AGE_MODE=0 scans round-robin from start; AGE_MODE=1 orders by ascending age, lower index first on ties.
module cdb_grant_select #(
  parameter int NUM_FU   = 6,
  parameter int LANES    = 2,
  parameter int PTR_W    = 3,
  parameter int KEY_W    = 4,
  parameter bit AGE_MODE = 1'b0
) (
  input  logic [NUM_FU-1:0]             pending,
  input  logic [PTR_W-1:0]              start,
  input  logic [NUM_FU-1:0][KEY_W-1:0]  age,
  output logic [LANES-1:0][NUM_FU-1:0]  lane_grant,
  output logic [NUM_FU-1:0]             grant,
  output logic [PTR_W-1:0]              next_start
);

  if (AGE_MODE) begin : g_age
    int   rank_s;
    logic unused_start_s;

    assign unused_start_s = ^start;

    // A slot's lane is the number of pending slots that must broadcast before it.
    always_comb begin
      lane_grant = '0;
      next_start = {PTR_W{1'b0}};
      rank_s     = 0;
      for (int i = 0; i < NUM_FU; i++) begin
        rank_s = 0;
        for (int j = 0; j < NUM_FU; j++) begin
          rank_s = rank_s + int'(pending[j] &&
                   ((age[j] < age[i]) || ((age[j] == age[i]) && (j < i))));
        end
        for (int k = 0; k < LANES; k++) begin
          lane_grant[k][i] = pending[i] && (rank_s == k);
        end
      end
    end
  end else begin : g_rr
    int   taken_s;
    logic hit_s;
    logic sel_s;
    logic unused_age_s;

    assign unused_age_s = ^age;

    // Walk indices from start with wrap; the n-th pending slot found takes lane n.
    always_comb begin
      lane_grant = '0;
      next_start = start;
      taken_s    = 0;
      hit_s      = 1'b0;
      sel_s      = 1'b0;
      for (int j = 0; j < NUM_FU; j++) begin
        for (int i = 0; i < NUM_FU; i++) begin
          hit_s = (i == ((int'(start) + j) % NUM_FU));
          sel_s = hit_s && pending[i] && (taken_s < LANES);
          for (int k = 0; k < LANES; k++) begin
            lane_grant[k][i] = lane_grant[k][i] | (sel_s && (taken_s == k));
          end
          next_start = sel_s ? PTR_W'((i + 1) % NUM_FU) : next_start;
          taken_s    = taken_s + int'(sel_s);
        end
      end
    end
  end

  // Collapse lane grants into one per-FU grant vector.
  always_comb begin
    grant = {NUM_FU{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      grant = grant | lane_grant[k];
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per FU, up to CDB_LANES grants per cycle onto a registered CDB.
// Define CDB_ARB_AGE_PRIO_EN to grant oldest-first (by ROB age) instead of round-robin.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = 6,
  parameter int CDB_LANES = CDB_SIZE_P
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_FU-1:0]       fu_valid,
  input  cdb_entry_t [NUM_FU-1:0] fu_result,
  output logic [NUM_FU-1:0]       fu_ready,
  input  rob_index_t              rob_head,
  output cdb_packet_t             cdb
);

  localparam int CDB_ARB_PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
`ifdef CDB_ARB_AGE_PRIO_EN
  localparam bit AGE_MODE = 1'b1;
`else
  localparam bit AGE_MODE = 1'b0;
`endif

  logic [NUM_FU-1:0]                 pending_r;
  cdb_entry_t [NUM_FU-1:0]           slot_r;
  logic [CDB_ARB_PTR_W-1:0]          rr_ptr_r;
  cdb_packet_t                       cdb_r;
  rob_index_t [NUM_FU-1:0]           age_s;
  logic [CDB_LANES-1:0][NUM_FU-1:0]  lane_grant_s;
  logic [NUM_FU-1:0]                 grant_s;
  logic [CDB_ARB_PTR_W-1:0]          next_ptr_s;
  logic                              clear_s;
  logic [NUM_FU-1:0]                 load_s;
  cdb_packet_t                       cdb_next_s;

  assign clear_s  = rst | flush;
  assign fu_ready = clear_s ? {NUM_FU{1'b0}} : (~pending_r | grant_s);
  assign load_s   = fu_valid & fu_ready;
  assign cdb      = cdb_r;

  // Age of each held result relative to the ROB head.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      age_s[i] = rob_age(slot_r[i].reorder, rob_head);
    end
  end

  cdb_grant_select #(
    .NUM_FU   (NUM_FU),
    .LANES    (CDB_LANES),
    .PTR_W    (CDB_ARB_PTR_W),
    .KEY_W    (ROB_IDX_W),
    .AGE_MODE (AGE_MODE)
  ) u_grant_select (
    .pending    (pending_r),
    .start      (rr_ptr_r),
    .age        (age_s),
    .lane_grant (lane_grant_s),
    .grant      (grant_s),
    .next_start (next_ptr_s)
  );

  // Grants are one-hot per lane, so an AND-OR mux picks each lane's slot.
  always_comb begin
    cdb_next_s = '0;
    for (int k = 0; k < CDB_LANES; k++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        cdb_next_s[k] = cdb_next_s[k] | (slot_r[i] & {$bits(cdb_entry_t){lane_grant_s[k][i]}});
      end
      cdb_next_s[k].valid = |lane_grant_s[k];
    end
  end

  // Occupancy, pointer and bus registers; rst and flush both return to idle.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      pending_r <= {NUM_FU{1'b0}};
      rr_ptr_r  <= {CDB_ARB_PTR_W{1'b0}};
      cdb_r     <= '0;
    end else begin
      pending_r <= load_s | (pending_r & ~grant_s);
      rr_ptr_r  <= (|grant_s) ? next_ptr_s : rr_ptr_r;
      cdb_r     <= cdb_next_s;
    end
  end

  // Slot payloads need no reset; pending_r qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (load_s[i]) begin
        slot_r[i] <= fu_result[i];
      end else begin
        slot_r[i] <= slot_r[i];
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the common data bus (CDB, `CDB_SIZE lanes) among NUM_FU functional-unit result producers.
- Each FU hands one result into a private one-entry holding slot via valid/ready.
- Each cycle the arbiter grants up to CDB_LANES pending slots, round-robin, and registers them onto the CDB.
- The CDB feeds the register status table, the reservation stations and the ROB.

Parameters:
- NUM_FU, 6, number of requesting functional units (>= 1).
- CDB_LANES, `CDB_SIZE, number of CDB lanes driven (1 <= CDB_LANES <= NUM_FU).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush (mispredict/exception); synchronous, same effect as rst.
- fu_valid  in  NUM_FU  FU i presents a result.
- fu_result  in  NUM_FU x cdb_entry_t  per-FU result; .reorder (rob_index_t) and .value; .valid ignored.
- fu_ready  out  NUM_FU  slot i can accept this cycle.
- rob_head  in  rob_index_t  oldest ROB index (used only with CDB_ARB_AGE_PRIO_EN).
- cdb  out  cdb_packet_t  registered broadcast; lanes >= CDB_LANES tied 0.

Behaviour:
- Clock and reset: single clock clk; rst synchronous, active-high.
- State:
  - pending[NUM_FU] with slot_data[NUM_FU].
  - rr_ptr, $clog2(NUM_FU) bits.
  - cdb register.
- Reset/flush values:
  - pending = 0, rr_ptr = 0, cdb = '0 (all lanes .valid = 0).
  - fu_ready = 0 during any cycle with rst or flush high.
  - fu_valid is ignored in that cycle; results already on the bus in that cycle still broadcast (consumers handle flush themselves).
- Handshake:
  - fu_ready[i] = !pending[i] || grant[i], combinational, no dependency on fu_valid.
  - Transfer occurs when fu_valid[i] && fu_ready[i]; slot i loads fu_result[i] and pending[i] = 1 at the edge.
  - A granted slot may reload in the same cycle (full throughput of 1 result/cycle/FU).
- Arbitration (combinational, each cycle):
  - Scan FU indices starting at rr_ptr, wrapping modulo NUM_FU.
  - Grant the first min(CDB_LANES, popcount(pending)) pending slots.
  - The k-th grant goes to lane k (k = 0 first).
  - Ungranted lanes carry .valid = 0.
- rr_ptr update: if any grant, rr_ptr <= (index of last granted FU + 1) mod NUM_FU; otherwise unchanged.
- Output: cdb <= granted slot contents with .valid = 1.
- Latency: fu handshake at edge E, slot visible cycle after E, cdb valid one edge later. Minimum latency 2 edges; no bypass.
- Starvation bound: with all FUs pending continuously, every pending slot is granted within ceil(NUM_FU/CDB_LANES) cycles.
- Each slot holds exactly one result. No reordering within an FU; no duplication; no drop except on rst/flush.
- Boundary cases:
  - No pending slots: cdb all invalid.
  - Exactly CDB_LANES pending: all granted.
  - rr_ptr wraps from NUM_FU-1 to 0.
  - NUM_FU == CDB_LANES: every pending slot granted every cycle.
- Simultaneous flush and fu_valid: no transfer, slots cleared.

Optional Feature:
- Macro CDB_ARB_AGE_PRIO_EN.
- Defined: grant order is by ascending age = (slot.reorder - rob_head) mod ROB size, ties resolved by lower FU index; rr_ptr is unused and held at 0. The oldest result always broadcasts first, which speeds branch resolution.
- Undefined: round-robin as above; the rob_head input is unused (lint-waived).

Decomposition:
- cpu_defs: cdb_entry_t {valid, reorder, value}, cdb_packet_t = cdb_entry_t [`CDB_SIZE-1:0], rob_index_t, `CDB_SIZE.
- Add constant CDB_ARB_PTR_W = $clog2(NUM_FU) locally.
- One sub-module: cdb_grant_select, the purely combinational multi-grant picker (pending, start pointer or age keys -> per-lane one-hot grants). It is reused for both modes and tested standalone.

Test Plan:
- Reset then idle: rst 1 cycle, fu_valid = 0 -> cdb lanes all .valid = 0, fu_ready = all 1 after reset cycle, rr_ptr = 0.
- Single result: NUM_FU=6, CDB_LANES=2, FU3 sends reorder=5, value=0x1234 at edge E -> lane0 valid, reorder 5, value 0x1234 at E+2; lane1 invalid.
- Contention: all 6 FUs pending, rr_ptr=0 -> grants {0,1}, then {2,3}, then {4,5}. Each FU reloads every third cycle; fu_ready[i] high only in its grant cycle.
- Wrap: pending {5,0,2}, rr_ptr=5 -> grants 5 (lane0), 0 (lane1); next cycle rr_ptr=1, grant 2.
- Flush mid-stream: 4 slots pending, flush=1 with fu_valid=all 1 -> fu_ready=0, next cycle pending=0, cdb invalid; FU results presented after the flush cycle broadcast normally.
- Age priority (macro defined): rob_head=14 (16-entry ROB), FU1 reorder 2, FU4 reorder 15, FU0 reorder 0, CDB_LANES=2 -> lane0=FU4, lane1=FU0, FU1 next cycle.
